// File: rtl/regfile_wb_pkg.sv
// rtl/regfile_wb_pkg.sv - shared types and constants for the register-file write-back arbiter
package regfile_wb_pkg;

    localparam int REG_COUNT = 32;
    localparam int WB_ADDRW  = 5;
    localparam int WB_DATAW  = 64;

    typedef enum logic [0:0] {
        WB_EMPTY = 1'b0,
        WB_HOLD  = 1'b1
    } wb_state_e;

    typedef struct packed {
        logic [WB_ADDRW-1:0] rd;
        logic [WB_DATAW-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_sb.sv
// rtl/regfile_wb_sb.sv - per-register busy scoreboard for long-latency destinations
// Ports: i_clk/i_rst_n clock and async active-low reset; i_set_en/i_set_rd mark a
// register busy; i_clr_en/i_clr_rd release it; o_busy is the registered busy vector.
// A set and clear of the same register in one cycle leaves it busy; bit 0 never sets.
module regfile_wb_sb
    import regfile_wb_pkg::*;
#(
    parameter int ADDRW = 5
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_set_en,
    input  logic [ADDRW-1:0]     i_set_rd,
    input  logic                 i_clr_en,
    input  logic [ADDRW-1:0]     i_clr_rd,
    output logic [REG_COUNT-1:0] o_busy
);

    logic [REG_COUNT-1:0] busy_q;
    logic [REG_COUNT-1:0] busy_d;

    // Clear is applied first so a same-cycle set of the same index overrides it.
    always_comb begin
        busy_d = busy_q;
        if (i_clr_en) begin
            busy_d[i_clr_rd] = 1'b0;
        end
        if (i_set_en) begin
            busy_d[i_set_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign o_busy = busy_q;

endmodule

// File: rtl/regfile_wb.sv
// rtl/regfile_wb.sv - write-back arbiter merging pipeline (A) and long-latency (B) results
// Ports: i_clk/i_rst_n clock and async active-low reset; i_iss_* issue-side destination
// tracking; i_a_*/o_a_ready pipeline result port; i_b_*/o_b_ready long-unit result port;
// o_wen/o_waddr/o_wdata registered register-file write port; o_busy busy scoreboard.
// Optional macro REGFILE_WB_STARVE_GUARD_EN: after STARVE_MAX cycles of a held B result
// being blocked by A, A is refused for one cycle so the held result drains.
module regfile_wb
    import regfile_wb_pkg::*;
#(
    parameter int CPU_WIDTH  = 64,
    parameter int REG_ADDRW  = 5,
    parameter int STARVE_MAX = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_iss_valid,
    input  logic                 i_iss_long,
    input  logic [REG_ADDRW-1:0] i_iss_rd,
    input  logic                 i_a_valid,
    output logic                 o_a_ready,
    input  logic [REG_ADDRW-1:0] i_a_rd,
    input  logic [CPU_WIDTH-1:0] i_a_data,
    input  logic                 i_b_valid,
    output logic                 o_b_ready,
    input  logic [REG_ADDRW-1:0] i_b_rd,
    input  logic [CPU_WIDTH-1:0] i_b_data,
    output logic                 o_wen,
    output logic [REG_ADDRW-1:0] o_waddr,
    output logic [CPU_WIDTH-1:0] o_wdata,
    output logic [31:0]          o_busy
);

    wb_state_e            state_q, state_d;
    wb_req_t              hold_q, hold_d;
    logic                 wen_q, wen_d;
    logic [REG_ADDRW-1:0] waddr_q, waddr_d;
    logic [CPU_WIDTH-1:0] wdata_q, wdata_d;

    logic                 a_acc;
    logic                 b_acc;
    logic                 guard_fire;
    logic                 commit_en;
    logic                 clr_en;
    wb_req_t              commit_req;

`ifdef REGFILE_WB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 2);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign guard_fire = (state_q == WB_HOLD) && (cnt_q >= CNT_W'(STARVE_MAX));

    // Counts A wins over a held B; any exit from HOLD (including the guard drain) restarts it.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != WB_HOLD) begin
            cnt_d = '0;
        end else if ((state_q == WB_HOLD) && a_acc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    localparam int unused_starve_max = STARVE_MAX;

    assign guard_fire = 1'b0;
`endif

    // Readies depend only on registered state so they never loop through the valids.
    assign o_a_ready = !guard_fire;
    assign o_b_ready = (state_q == WB_EMPTY);

    assign a_acc = i_a_valid && o_a_ready;
    assign b_acc = i_b_valid && o_b_ready;

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        commit_en  = 1'b0;
        clr_en     = 1'b0;
        commit_req = hold_q;
        if (guard_fire) begin
            commit_en = 1'b1;
            clr_en    = 1'b1;
            state_d   = WB_EMPTY;
        end else if (a_acc) begin
            commit_en       = 1'b1;
            commit_req.rd   = i_a_rd;
            commit_req.data = i_a_data;
            if (b_acc) begin
                hold_d.rd   = i_b_rd;
                hold_d.data = i_b_data;
                state_d     = WB_HOLD;
            end
        end else if (state_q == WB_HOLD) begin
            commit_en = 1'b1;
            clr_en    = 1'b1;
            state_d   = WB_EMPTY;
        end else if (b_acc) begin
            commit_en       = 1'b1;
            clr_en          = 1'b1;
            commit_req.rd   = i_b_rd;
            commit_req.data = i_b_data;
        end
    end

    // x0 writes complete the handshake but never reach the register file.
    always_comb begin
        wen_d   = commit_en && (commit_req.rd != '0);
        waddr_d = commit_en ? commit_req.rd : waddr_q;
        wdata_d = commit_en ? commit_req.data : wdata_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= WB_EMPTY;
            hold_q  <= '0;
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign o_wen   = wen_q;
    assign o_waddr = waddr_q;
    assign o_wdata = wdata_q;

    regfile_wb_sb #(
        .ADDRW (REG_ADDRW)
    ) u_sb (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_set_en (i_iss_valid && i_iss_long && (i_iss_rd != '0)),
        .i_set_rd (i_iss_rd),
        .i_clr_en (clr_en),
        .i_clr_rd (commit_req.rd),
        .o_busy   (o_busy)
    );

endmodule

// File: tb/tb_regfile_wb.sv
// tb/tb_regfile_wb.sv - scoreboard testbench for regfile_wb
module tb_regfile_wb;

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] data;
    } exp_t;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_iss_valid, i_iss_long;
    logic [4:0]  i_iss_rd;
    logic        i_a_valid, o_a_ready;
    logic [4:0]  i_a_rd;
    logic [63:0] i_a_data;
    logic        i_b_valid, o_b_ready;
    logic [4:0]  i_b_rd;
    logic [63:0] i_b_data;
    logic        o_wen;
    logic [4:0]  o_waddr;
    logic [63:0] o_wdata;
    logic [31:0] o_busy;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    regfile_wb #(
        .CPU_WIDTH  (64),
        .REG_ADDRW  (5),
        .STARVE_MAX (4)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_iss_valid (i_iss_valid),
        .i_iss_long  (i_iss_long),
        .i_iss_rd    (i_iss_rd),
        .i_a_valid   (i_a_valid),
        .o_a_ready   (o_a_ready),
        .i_a_rd      (i_a_rd),
        .i_a_data    (i_a_data),
        .i_b_valid   (i_b_valid),
        .o_b_ready   (o_b_ready),
        .i_b_rd      (i_b_rd),
        .i_b_data    (i_b_data),
        .o_wen       (o_wen),
        .o_waddr     (o_waddr),
        .o_wdata     (o_wdata),
        .o_busy      (o_busy)
    );

    always #5 i_clk = ~i_clk;

    // Every register-file write is matched, in order, against the expected queue.
    always @(negedge i_clk) begin
        if (i_rst_n && o_wen) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_write got waddr=%0d wdata=%0h want no write", o_waddr, o_wdata);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (o_waddr !== e.rd || o_wdata !== e.data)
                    $display("FAIL write_order got waddr=%0d wdata=%0h want waddr=%0d wdata=%0h",
                             o_waddr, o_wdata, e.rd, e.data);
                else
                    n_pass++;
            end
        end
    end

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle();
        i_iss_valid = 1'b0; i_iss_long = 1'b0; i_iss_rd = '0;
        i_a_valid = 1'b0; i_a_rd = '0; i_a_data = '0;
        i_b_valid = 1'b0; i_b_rd = '0; i_b_data = '0;
    endtask

    task automatic push(input logic [4:0] rd, input logic [63:0] data);
        exp_t e;
        e.rd = rd;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        idle();
        cyc(); cyc();
        n_checks++; if (o_wen !== 1'b0) $display("FAIL rst_wen got %0b want 0", o_wen); else n_pass++;
        n_checks++; if (o_waddr !== 5'd0) $display("FAIL rst_waddr got %0d want 0", o_waddr); else n_pass++;
        n_checks++; if (o_wdata !== 64'd0) $display("FAIL rst_wdata got %0h want 0", o_wdata); else n_pass++;
        n_checks++; if (o_busy !== 32'd0) $display("FAIL rst_busy got %0h want 0", o_busy); else n_pass++;
        n_checks++; if (o_a_ready !== 1'b1) $display("FAIL rst_a_ready got %0b want 1", o_a_ready); else n_pass++;
        n_checks++; if (o_b_ready !== 1'b1) $display("FAIL rst_b_ready got %0b want 1", o_b_ready); else n_pass++;
        i_rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_a_basic();
        i_a_valid = 1'b1; i_a_rd = 5'd5; i_a_data = 64'h11;
        push(5'd5, 64'h11);
        cyc();
        idle();
        n_checks++;
        if (o_wen !== 1'b1 || o_waddr !== 5'd5 || o_wdata !== 64'h11)
            $display("FAIL a_basic_write got wen=%0b waddr=%0d wdata=%0h want 1/5/11", o_wen, o_waddr, o_wdata);
        else n_pass++;
        cyc();
        n_checks++; if (o_wen !== 1'b0) $display("FAIL a_basic_pulse got wen=%0b want 0", o_wen); else n_pass++;
    endtask

    task automatic test_b_busy();
        i_iss_valid = 1'b1; i_iss_long = 1'b1; i_iss_rd = 5'd7;
        cyc();
        idle();
        n_checks++; if (o_busy[7] !== 1'b1) $display("FAIL busy_set got %0b want 1", o_busy[7]); else n_pass++;
        i_b_valid = 1'b1; i_b_rd = 5'd7; i_b_data = 64'hAB;
        push(5'd7, 64'hAB);
        cyc();
        idle();
        n_checks++;
        if (o_wen !== 1'b1 || o_waddr !== 5'd7)
            $display("FAIL b_direct_write got wen=%0b waddr=%0d want 1/7", o_wen, o_waddr);
        else n_pass++;
        n_checks++; if (o_busy[7] !== 1'b0) $display("FAIL busy_clear got %0b want 0", o_busy[7]); else n_pass++;
        cyc();
    endtask

    task automatic test_collision();
        i_a_valid = 1'b1; i_a_rd = 5'd3; i_a_data = 64'h33;
        i_b_valid = 1'b1; i_b_rd = 5'd9; i_b_data = 64'h99;
        push(5'd3, 64'h33);
        push(5'd9, 64'h99);
        cyc();
        idle();
        n_checks++; if (o_waddr !== 5'd3) $display("FAIL coll_first got waddr=%0d want 3", o_waddr); else n_pass++;
        n_checks++; if (o_b_ready !== 1'b0) $display("FAIL coll_b_ready_hold got %0b want 0", o_b_ready); else n_pass++;
        cyc();
        n_checks++;
        if (o_wen !== 1'b1 || o_waddr !== 5'd9)
            $display("FAIL coll_second got wen=%0b waddr=%0d want 1/9", o_wen, o_waddr);
        else n_pass++;
        n_checks++; if (o_b_ready !== 1'b1) $display("FAIL coll_b_ready_back got %0b want 1", o_b_ready); else n_pass++;
        cyc();
    endtask

    task automatic test_set_wins();
        i_iss_valid = 1'b1; i_iss_long = 1'b1; i_iss_rd = 5'd4;
        cyc();
        i_b_valid = 1'b1; i_b_rd = 5'd4; i_b_data = 64'h44;
        push(5'd4, 64'h44);
        cyc();
        idle();
        n_checks++; if (o_busy[4] !== 1'b1) $display("FAIL set_wins got %0b want 1", o_busy[4]); else n_pass++;
        i_b_valid = 1'b1; i_b_rd = 5'd4; i_b_data = 64'h45;
        push(5'd4, 64'h45);
        cyc();
        idle();
        n_checks++; if (o_busy[4] !== 1'b0) $display("FAIL set_wins_release got %0b want 0", o_busy[4]); else n_pass++;
        cyc();
    endtask

    task automatic test_rd0();
        i_a_valid = 1'b1; i_a_rd = 5'd0; i_a_data = 64'hFF;
        cyc();
        idle();
        n_checks++; if (o_wen !== 1'b0) $display("FAIL rd0_wen got %0b want 0", o_wen); else n_pass++;
        i_iss_valid = 1'b1; i_iss_long = 1'b1; i_iss_rd = 5'd0;
        cyc();
        idle();
        n_checks++; if (o_busy !== 32'd0) $display("FAIL rd0_busy got %0h want 0", o_busy); else n_pass++;
        cyc();
    endtask

    // Continuous A stream against one held B result; the model tracks the guard counter.
    task automatic test_starve();
        int  idx;
        bit  m_hold;
        int  m_cnt;
        bit  exp_ready;
        idx = 0; m_hold = 0; m_cnt = 0;
`ifdef REGFILE_WB_STARVE_GUARD_EN
        for (int i = 0; i < 5; i++) push(5'd10 + 5'(i), 64'h100 + 64'(i));
        push(5'd20, 64'hB0B);
        for (int i = 5; i < 8; i++) push(5'd10 + 5'(i), 64'h100 + 64'(i));
`else
        for (int i = 0; i < 8; i++) push(5'd10 + 5'(i), 64'h100 + 64'(i));
        push(5'd20, 64'hB0B);
`endif
        for (int c = 0; c < 14; c++) begin
            i_a_valid = (idx < 8);
            i_a_rd    = 5'd10 + 5'(idx);
            i_a_data  = 64'h100 + 64'(idx);
            i_b_valid = (c == 0);
            i_b_rd    = 5'd20;
            i_b_data  = 64'hB0B;
`ifdef REGFILE_WB_STARVE_GUARD_EN
            exp_ready = !(m_hold && m_cnt == 4);
`else
            exp_ready = 1'b1;
`endif
            if (i_a_valid) begin
                n_checks++;
                if (o_a_ready !== exp_ready)
                    $display("FAIL starve_a_ready cycle=%0d got %0b want %0b", c, o_a_ready, exp_ready);
                else n_pass++;
            end
            if (m_hold && !exp_ready) begin
                m_hold = 0; m_cnt = 0;
            end else if (i_a_valid && exp_ready) begin
                if (c == 0) m_hold = 1;
                else if (m_hold) m_cnt++;
            end else if (m_hold) begin
                m_hold = 0; m_cnt = 0;
            end
            if (i_a_valid && o_a_ready) idx++;
            cyc();
        end
        idle();
        cyc();
        n_checks++; if (idx !== 8) $display("FAIL starve_a_count got %0d want 8", idx); else n_pass++;
        n_checks++; if (exp_q.size() !== 0) $display("FAIL starve_drain got %0d pending want 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_reset_mid();
        i_iss_valid = 1'b1; i_iss_long = 1'b1; i_iss_rd = 5'd12;
        cyc();
        idle();
        i_a_valid = 1'b1; i_a_rd = 5'd2; i_a_data = 64'h22;
        i_b_valid = 1'b1; i_b_rd = 5'd12; i_b_data = 64'hCC;
        cyc();
        idle();
        i_rst_n = 1'b0;
        #1;
        n_checks++; if (o_wen !== 1'b0) $display("FAIL midrst_wen got %0b want 0", o_wen); else n_pass++;
        n_checks++; if (o_busy !== 32'd0) $display("FAIL midrst_busy got %0h want 0", o_busy); else n_pass++;
        n_checks++; if (o_b_ready !== 1'b1) $display("FAIL midrst_b_ready got %0b want 1", o_b_ready); else n_pass++;
        cyc();
        i_rst_n = 1'b1;
        cyc(); cyc(); cyc();
        n_checks++; if (o_wen !== 1'b0) $display("FAIL midrst_no_write got %0b want 0", o_wen); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_a_basic();
        test_b_busy();
        test_collision();
        test_set_wins();
        test_rd0();
        test_starve();
        test_reset_mid();
        n_checks++;
        if (exp_q.size() !== 0) $display("FAIL final_drain got %0d pending want 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_wb.md
# regfile_wb

Write-back arbiter that drives the integer register file's single write port and tracks destination registers of in-flight long-latency operations. It merges the in-order pipeline result stream (port A) with results from a long-latency unit such as a multiplier/divider or load unit (port B). It also exports a per-register busy scoreboard so issue logic can stall on RAW hazards. It sits between the execute/memory stages and the register file.

## Interface
- CPU_WIDTH, 64, data width (matches `CPU_WIDTH)
- REG_ADDRW, 5, register index width (matches `REG_ADDRW)
- STARVE_MAX, 4, consecutive cycles port B's held result may be blocked before port A is back-pressured (guard build only)

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_iss_valid  in  1  an instruction is issued this cycle
- i_iss_long  in  1  issued instruction completes via port B
- i_iss_rd  in  REG_ADDRW  destination of issued instruction
- i_a_valid  in  1  pipeline result valid
- o_a_ready  out  1  port A accepted this cycle
- i_a_rd  in  REG_ADDRW  pipeline destination
- i_a_data  in  CPU_WIDTH  pipeline result
- i_b_valid  in  1  long-unit result valid
- o_b_ready  out  1  port B can accept
- i_b_rd  in  REG_ADDRW  long-unit destination
- i_b_data  in  CPU_WIDTH  long-unit result
- o_wen  out  1  register file write enable
- o_waddr  out  REG_ADDRW  register file write index
- o_wdata  out  CPU_WIDTH  register file write data
- o_busy  out  32  bit r set means register r awaits a port-B result

## Operation
- Handshake: transfer on valid&&ready. Valid holds its payload until accepted.
- One-entry hold buffer for port B. FSM has two states:
  - EMPTY: o_b_ready=1.
  - HOLD: o_b_ready=0.
- Arbitration each cycle, in priority order:
  1. If the guard fires, HOLD commits and A is refused.
  2. Otherwise, if A is accepted, A commits. A B-transfer arriving in the same cycle goes to the hold buffer (EMPTY→HOLD).
  3. Otherwise HOLD commits (HOLD→EMPTY). In the same cycle o_b_ready stays 0.
  4. Otherwise, in EMPTY, a B transfer commits directly and the state stays EMPTY.
- At most one commit per cycle. A committed write to rd=0 produces o_wen=0 but still completes the handshake and clears nothing.
- Scoreboard:
  - Set o_busy[rd] on i_iss_valid&&i_iss_long&&rd!=0.
  - Clear o_busy[rd] when a port-B result (direct or held) commits.
  - If set and clear hit the same rd in one cycle, set wins.
  - o_busy[0] is always 0.
- A port-B result for a register whose busy bit is clear still commits. The scoreboard is not a checker.

## Timing
- Reset values:
  - o_wen=0, o_waddr=0, o_wdata=0
  - o_busy=0
  - FSM=EMPTY, starvation counter=0
  - o_b_ready=1, o_a_ready=1
- Write port outputs are registered: commit decision in cycle N gives o_wen/o_waddr/o_wdata in cycle N+1, held for exactly one cycle.
- o_busy is registered, so a clear is visible the cycle after commit, together with o_wen. Issue logic bypasses via o_waddr/o_wdata if needed.
- o_a_ready and o_b_ready are combinational from state/counter only, never from the valids.
- Reset asserted mid-operation discards the held result and clears the scoreboard. No write is emitted after reset deassertion until a new commit.

## Configuration
- REGFILE_WB_STARVE_GUARD_EN defined:
  - A counter increments each cycle in HOLD while A is accepted, and resets on leaving HOLD.
  - When the counter reaches STARVE_MAX, o_a_ready=0 for one cycle and HOLD commits.
- Not defined:
  - o_a_ready is tied to 1 and A has absolute priority.
  - A continuous A stream may block HOLD indefinitely.
  - The STARVE_MAX parameter is unused.

## Structure
- Shared package holds:
  - the FSM state enum (WB_EMPTY, WB_HOLD)
  - a typedef for a write-back request struct {rd, data}
  - the REG_COUNT constant
- One sub-module, regfile_wb_sb: the 32-entry busy scoreboard with set/clear ports and set-wins priority.

## Test plan
- Reset, then A rd=5 data=0x11 → next cycle o_wen=1, o_waddr=5, o_wdata=0x11; the cycle after that o_wen=0.
- Issue long rd=7 → o_busy[7]=1 next cycle. B rd=7 data=0xAB alone → o_wen with waddr=7 next cycle, and o_busy[7]=0 in that same cycle.
- A rd=3 and B rd=9 in the same cycle → write rd=3, then rd=9 on the following cycle. o_b_ready=0 for exactly one cycle.
- Issue long rd=4 in the same cycle a B rd=4 commits → o_busy[4] stays 1.
- A rd=0 data=0xFF → o_wen stays 0. Issue long rd=0 → o_busy stays 0.
- Guard build with STARVE_MAX=4: A valid every cycle while B is held → o_a_ready drops on the 5th HOLD cycle and the held B writes next cycle. In the non-guard build, B is written only after A stops.
